// File: rtl/mem_phase_sequencer_if.sv
// Purpose: bundles the UART, processor and data-memory signals of the phase sequencer.
// Latency: none; wires only.
// Backpressure: none; the UART and processor pace the sequencer with done/over pulses.
interface mem_phase_sequencer_if #(
    parameter int ADDR_W = 18
);
    logic              rx_done;
    logic [7:0]        rx_data;
    logic              pro_wr;
    logic [ADDR_W-1:0] pro_addr;
    logic [7:0]        pro_dout;
    logic              pro_over;
    logic              tx_done;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [7:0]        dm_din;
    logic              pro_hold;
    logic              tx_start;
    logic              rx_finish;
    logic              tx_finish;
    logic [1:0]        phase;

    modport master (
        output rx_done, rx_data, pro_wr, pro_addr, pro_dout, pro_over, tx_done,
        input  dm_we, dm_addr, dm_din, pro_hold, tx_start, rx_finish, tx_finish, phase
    );

    modport slave (
        input  rx_done, rx_data, pro_wr, pro_addr, pro_dout, pro_over, tx_done,
        output dm_we, dm_addr, dm_din, pro_hold, tx_start, rx_finish, tx_finish, phase
    );
endinterface

// File: rtl/mem_phase_sequencer.sv
// Purpose: owns the data-memory port through receive, process and transmit phases.
// Latency: RX write one cycle after rx_done; PROC writes pass through; TX fires two cycles after each step.
// Backpressure: none; TX waits for tx_done before the next byte, ignores stray pulses.
module mem_phase_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int RX_COUNT = 65536,
    parameter int TX_COUNT = 16384,
    parameter int TX_BASE  = 0
) (
    input logic                   clk,
    input logic                   rst,
    mem_phase_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        PH_RX   = 2'd0,
        PH_PROC = 2'd1,
        PH_TX   = 2'd2,
        PH_DONE = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        TX_SETUP = 2'd0,
        TX_FIRE  = 2'd1,
        TX_WAIT  = 2'd2
    } tx_state_t;

    localparam logic [ADDR_W:0]   RX_END    = (ADDR_W+1)'(RX_COUNT);
    localparam logic [ADDR_W:0]   TX_END    = (ADDR_W+1)'(TX_COUNT);
    localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);

    phase_t            phase;
    tx_state_t         tx_st;
    logic [ADDR_W:0]   rx_cnt;
    logic [ADDR_W:0]   tx_cnt;
    logic [ADDR_W:0]   tx_cnt_nxt;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              tx_start_q;
    logic              rx_finish_q;
    logic              tx_finish_q;
    logic              rx_accept;

    // The counter saturates at RX_END, so late bytes are dropped rather than wrapping.
    assign rx_accept  = bus.rx_done && (rx_cnt != RX_END);
    assign tx_cnt_nxt = tx_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= PH_RX;
            tx_st       <= TX_SETUP;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            wr_pend     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            tx_start_q  <= 1'b0;
            rx_finish_q <= 1'b0;
            tx_finish_q <= 1'b0;
        end else begin
            wr_pend    <= 1'b0;
            tx_start_q <= 1'b0;
            case (phase)
                PH_RX: begin
                    if (rx_accept) begin
                        wr_pend <= 1'b1;
                        wr_addr <= rx_cnt[ADDR_W-1:0];
                        wr_data <= bus.rx_data;
                        rx_cnt  <= rx_cnt + 1'b1;
                    end
                    // Reaching RX_END coincides with the final write cycle (or reset when empty).
                    if (rx_cnt == RX_END) begin
                        phase       <= PH_PROC;
                        rx_finish_q <= 1'b1;
                    end
                end
                PH_PROC: begin
                    if (bus.pro_over) begin
                        tx_cnt <= '0;
                        tx_st  <= TX_SETUP;
                        if (TX_END == '0) begin
                            phase       <= PH_DONE;
                            tx_finish_q <= 1'b1;
                        end else begin
                            phase <= PH_TX;
                        end
                    end
                end
                PH_TX: begin
                    case (tx_st)
                        TX_SETUP: begin
                            tx_st      <= TX_FIRE;
                            tx_start_q <= 1'b1;
                        end
                        TX_FIRE: begin
                            tx_st <= TX_WAIT;
                        end
                        TX_WAIT: begin
                            if (bus.tx_done) begin
                                tx_cnt <= tx_cnt_nxt;
                                if (tx_cnt_nxt == TX_END) begin
                                    phase       <= PH_DONE;
                                    tx_finish_q <= 1'b1;
                                end else begin
                                    tx_st <= TX_SETUP;
                                end
                            end
                        end
                        default: begin
                            tx_st <= TX_SETUP;
                        end
                    endcase
                end
                PH_DONE: begin
                    phase <= PH_DONE;
                end
            endcase
        end
    end

    logic              dm_we_c;
    logic [ADDR_W-1:0] dm_addr_c;
    logic [7:0]        dm_din_c;

    // The processor owns the memory port outright while it runs.
    always_comb begin
        dm_we_c   = 1'b0;
        dm_addr_c = '0;
        dm_din_c  = '0;
        case (phase)
            PH_RX: begin
                dm_we_c   = wr_pend;
                dm_addr_c = wr_addr;
                dm_din_c  = wr_data;
            end
            PH_PROC: begin
                dm_we_c   = bus.pro_wr;
                dm_addr_c = bus.pro_addr;
                dm_din_c  = bus.pro_dout;
            end
            PH_TX: begin
                dm_addr_c = TX_BASE_A + tx_cnt[ADDR_W-1:0];
            end
            default: begin
                dm_we_c = 1'b0;
            end
        endcase
    end

    assign bus.dm_we     = dm_we_c;
    assign bus.dm_addr   = dm_addr_c;
    assign bus.dm_din    = dm_din_c;
    assign bus.pro_hold  = (phase != PH_PROC);
    assign bus.tx_start  = tx_start_q;
    assign bus.rx_finish = rx_finish_q;
    assign bus.tx_finish = tx_finish_q;
    assign bus.phase     = phase;
endmodule

// File: tb/tb_mem_phase_sequencer.sv
// Bench for mem_phase_sequencer: random RX bytes, processor writes and UART pacing
// against expected memory writes and transmit addresses held in scoreboard queues.
module tb_mem_phase_sequencer;
    localparam int AW  = 18;
    localparam int RXC = 4;
    localparam int TXC = 2;
    localparam int TXB = 'h10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_phase_sequencer_if #(.ADDR_W(AW)) bus ();
    mem_phase_sequencer_if #(.ADDR_W(AW)) zb ();

    mem_phase_sequencer #(.ADDR_W(AW), .RX_COUNT(RXC), .TX_COUNT(TXC), .TX_BASE(TXB)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_phase_sequencer #(.ADDR_W(AW), .RX_COUNT(0), .TX_COUNT(0), .TX_BASE(0)) u_zero (
        .clk (clk),
        .rst (rst),
        .bus (zb)
    );

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_wr[$];
    exp_t exp_tx[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every memory write and every tx_start must match the head of its queue.
    logic [AW-1:0] prev_addr = '0;
    bit            last_rx_wr = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (last_rx_wr) begin
            check("rx_to_proc_phase", bus.phase, 1);
            check("rx_finish_set", bus.rx_finish, 1);
            check("pro_hold_released", bus.pro_hold, 0);
        end
        if (bus.dm_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                fail("spurious_write");
            end else begin
                e = exp_wr.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", bus.dm_addr, e.addr);
                check("wr_data", bus.dm_din, e.data);
            end
        end
        if (bus.tx_start === 1'b1) begin
            if (exp_tx.size() == 0) begin
                fail("spurious_tx_start");
            end else begin
                e = exp_tx.pop_front();
                check("tx_cycle", cyc, e.cyc);
                check("tx_addr_fire", bus.dm_addr, e.addr);
                check("tx_addr_setup", prev_addr, e.addr);
            end
        end
        if (bus.phase >= 2'd2) check("tx_din_zero", bus.dm_din, 0);
        last_rx_wr = (bus.dm_we === 1'b1) && (bus.phase == 2'd0) && (bus.dm_addr == AW'(RXC - 1));
        prev_addr  = bus.dm_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rx_done  = 1'b0;
        bus.pro_wr   = 1'b0;
        bus.pro_over = 1'b0;
        bus.tx_done  = 1'b0;
    endtask

    task automatic do_rx(input bit fixed);
        int         n;
        int         gap;
        int         t;
        logic [7:0] d;
        n = 0;
        while (n < RXC) begin
            gap = (n == 1) ? 0 : int'($urandom_range(0, 2));
            repeat (gap) tick();
            tick();
            d = fixed ? 8'(8'h11 * (n + 1)) : 8'($urandom);
            bus.rx_done = 1'b1;
            bus.rx_data = d;
            exp_wr.push_back('{cyc + 1, AW'(n), d});
            n++;
        end
        t = 0;
        while (bus.phase != 2'd1 && t < 8) begin
            tick();
            t++;
        end
        check("rx_reaches_proc", bus.phase, 1);
        check("rx_writes_drained", exp_wr.size(), 0);
    endtask

    task automatic do_proc();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                bus.pro_wr   = 1'b1;
                bus.pro_addr = AW'(5);
                bus.pro_dout = 8'hA5;
            end else begin
                bus.pro_wr   = 1'($urandom);
                bus.pro_addr = AW'($urandom);
                bus.pro_dout = 8'($urandom);
            end
            if (bus.pro_wr) exp_wr.push_back('{cyc, bus.pro_addr, bus.pro_dout});
        end
        tick();
        bus.pro_over = 1'b1;
        exp_tx.push_back('{cyc + 2, AW'(TXB), 8'h00});
        tick();
        check("proc_to_tx_phase", bus.phase, 2);
        check("tx_pro_hold", bus.pro_hold, 1);
    endtask

    task automatic do_tx(input bit abort);
        int t;
        int w;
        for (int k = 0; k < TXC; k++) begin
            t = 0;
            while (bus.tx_start !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            if (bus.tx_start !== 1'b1) begin
                fail("tx_start_timeout");
                return;
            end
            tick();
            check("tx_start_single", bus.tx_start, 0);
            if (k == 0) begin
                bus.rx_done = 1'b1;
                bus.rx_data = 8'hEE;
            end
            if (abort) return;
            check("wait_hold_addr", bus.dm_addr, TXB + k);
            w = $urandom_range(0, 3);
            repeat (w) begin
                tick();
                check("wait_hold_addr", bus.dm_addr, TXB + k);
            end
            bus.tx_done = 1'b1;
            if (k + 1 < TXC) exp_tx.push_back('{cyc + 2, AW'(TXB + k + 1), 8'h00});
        end
        tick();
        check("done_phase", bus.phase, 3);
        check("done_tx_finish", bus.tx_finish, 1);
        check("done_pro_hold", bus.pro_hold, 1);
        check("done_rx_finish", bus.rx_finish, 1);
        check("tx_queue_drained", exp_tx.size(), 0);
    endtask

    initial begin
        bus.rx_done = 1'b0; bus.rx_data = '0; bus.pro_wr = 1'b0; bus.pro_addr = '0;
        bus.pro_dout = '0; bus.pro_over = 1'b0; bus.tx_done = 1'b0;
        zb.rx_done = 1'b0; zb.rx_data = '0; zb.pro_wr = 1'b0; zb.pro_addr = '0;
        zb.pro_dout = '0; zb.pro_over = 1'b0; zb.tx_done = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_phase", bus.phase, 0);
        check("rst_dm_we", bus.dm_we, 0);
        check("rst_dm_addr", bus.dm_addr, 0);
        check("rst_dm_din", bus.dm_din, 0);
        check("rst_pro_hold", bus.pro_hold, 1);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_rx_finish", bus.rx_finish, 0);
        check("rst_tx_finish", bus.tx_finish, 0);
        rst = 1'b0;

        // Empty receive and transmit counts skip straight through their phases.
        tick();
        check("zero_rx_phase", zb.phase, 1);
        check("zero_rx_finish", zb.rx_finish, 1);
        check("zero_pro_hold", zb.pro_hold, 0);
        zb.pro_over = 1'b1;
        tick();
        zb.pro_over = 1'b0;
        check("zero_tx_phase", zb.phase, 3);
        check("zero_tx_finish", zb.tx_finish, 1);
        check("zero_done_hold", zb.pro_hold, 1);

        // Stray tx_done and pro_over while receiving.
        bus.tx_done = 1'b1;
        tick();
        bus.pro_over = 1'b1;
        tick();
        tick();
        check("stray_phase", bus.phase, 0);
        check("stray_rx_finish", bus.rx_finish, 0);
        check("stray_no_write", bus.dm_we, 0);

        do_rx(1'b1);
        do_proc();
        do_tx(1'b0);
        repeat (3) tick();
        check("done_sticky", bus.phase, 3);

        // Second pass with random bytes, aborted by reset while waiting for tx_done.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerun_phase", bus.phase, 0);
        do_rx(1'b0);
        do_proc();
        do_tx(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_phase", bus.phase, 0);
        check("abort_dm_addr", bus.dm_addr, 0);
        check("abort_dm_we", bus.dm_we, 0);
        check("abort_pro_hold", bus.pro_hold, 1);
        check("abort_tx_start", bus.tx_start, 0);
        check("abort_rx_finish", bus.rx_finish, 0);
        check("abort_tx_finish", bus.tx_finish, 0);
        exp_wr.delete();
        exp_tx.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        repeat (10) tick();
        check("post_abort_phase", bus.phase, 0);
        check("post_abort_finish", bus.rx_finish, 0);
        check("post_abort_queues", exp_wr.size() + exp_tx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
